// File: rtl/vip_switch_input_scheduler_pkg.sv
// rtl/vip_switch_input_scheduler_pkg.sv - shared types and elaboration helpers for the video switch input scheduler
package vip_switch_pkg;

    localparam int MIN_INPUTS = 2;
    localparam int MAX_INPUTS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        IN_PKT   = 2'd2
    } sched_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit sel_width_ok(input int sel_width, input int num_inputs);
        return (sel_width >= clog2(num_inputs)) &&
               (num_inputs >= MIN_INPUTS) && (num_inputs <= MAX_INPUTS);
    endfunction

endpackage

// File: rtl/vip_switch_input_scheduler_if.sv
// rtl/vip_switch_input_scheduler_if.sv - per-input and output video stream bundle of the input scheduler
interface vip_switch_input_scheduler_if #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_WIDTH = 24
);
    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS-1:0]            in_sop;
    logic [NUM_INPUTS-1:0]            in_eop;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            in_ready;
    logic                             out_valid;
    logic                             out_sop;
    logic                             out_eop;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_ready;

    // master: input FIFOs plus output stage; slave: the scheduler
    modport master (
        output in_valid, in_sop, in_eop, in_data, out_ready,
        input  in_ready, out_valid, out_sop, out_eop, out_data
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_data, out_ready,
        output in_ready, out_valid, out_sop, out_eop, out_data
    );
endinterface

// File: rtl/vip_switch_input_scheduler_plane_counter.sv
// rtl/vip_switch_input_scheduler_plane_counter.sv - colour-plane position tracker with clear-on-sop and start-of-sample decode
module vip_switch_plane_counter
    import vip_switch_pkg::*;
#(
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    hd_sdn_i,
    input  logic                                    accept_i,
    input  logic                                    sop_i,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_o,
    output logic                                    start_of_sample_o
);
    localparam bit SINGLE_PLANE = (NUMBER_OF_COLOUR_PLANES == 1);
    localparam logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] PLANE_LAST =
        LOG2_NUMBER_OF_COLOUR_PLANES'(NUMBER_OF_COLOUR_PLANES - 1);

    logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_q;
    logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_d;
    logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_idx;

    // An sop beat is plane 0 whatever the register holds from the previous packet
    assign plane_idx = (SINGLE_PLANE || sop_i) ? '0 : plane_q;

    always_comb begin
        plane_d = plane_q;
        if (accept_i) begin
            plane_d = (SINGLE_PLANE || (plane_idx == PLANE_LAST)) ? '0 : plane_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plane_q <= '0;
        end else begin
            plane_q <= plane_d;
        end
    end

    assign plane_o           = plane_idx;
    assign start_of_sample_o = hd_sdn_i || SINGLE_PLANE || (plane_idx == '0);

endmodule

// File: rtl/vip_switch_input_scheduler.sv
// rtl/vip_switch_input_scheduler.sv - packet-boundary input scheduler; VIPSW_DRAIN_UNSELECTED_EN discards beats of unselected inputs
module vip_switch_input_scheduler
    import vip_switch_pkg::*;
#(
    parameter int NUM_INPUTS                   = 2,
    parameter int SEL_WIDTH                    = 3,
    parameter int DATA_WIDTH                   = 24,
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hd_sdn,
    input  logic [SEL_WIDTH-1:0] ctrl_sel,
    input  logic                 ctrl_commit,
    output logic                 ctrl_pending,
    output logic                 switch_done,
    output logic [SEL_WIDTH-1:0] active_sel,
    output logic                 err_partial_sample,
    output logic                 out_start_of_sample,
    vip_switch_input_scheduler_if.slave bus
);
    localparam bit SEL_WIDTH_OK = sel_width_ok(SEL_WIDTH, NUM_INPUTS);
    localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH + 1)'(NUM_INPUTS);
    localparam logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] PLANE_LAST =
        LOG2_NUMBER_OF_COLOUR_PLANES'(NUMBER_OF_COLOUR_PLANES - 1);

`ifdef VIPSW_DRAIN_UNSELECTED_EN
    localparam logic UNSEL_READY = 1'b1;
`else
    localparam logic UNSEL_READY = 1'b0;
`endif

    if (!SEL_WIDTH_OK) begin : g_bad_params
        $error("vip_switch_input_scheduler: SEL_WIDTH too small or NUM_INPUTS out of range");
    end

    sched_state_e           state_q, state_d;
    logic [SEL_WIDTH-1:0]   active_sel_q, active_sel_d;
    logic [SEL_WIDTH-1:0]   pend_sel_q, pend_sel_d;
    logic                   pend_q, pend_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   sel_valid, sel_sop, sel_eop;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   passing, draining, sel_ready;
    logic                   pkt_accept, eop_accept, pass_sop;
    logic                   commit_ok, have_pend, apply, err_set;
    logic [NUM_INPUTS-1:0]  in_ready;
    logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane;

    always_comb begin : input_mux
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (active_sel_q == SEL_WIDTH'(i)) begin
                sel_valid = bus.in_valid[i];
                sel_sop   = bus.in_sop[i];
                sel_eop   = bus.in_eop[i];
                sel_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // While hunting for a packet start, non-sop beats are silently consumed
    assign passing    = (state_q == IN_PKT) || ((state_q == WAIT_SOP) && sel_sop);
    assign draining   = (state_q == WAIT_SOP) && !sel_sop;
    assign sel_ready  = passing ? bus.out_ready : draining;
    assign pkt_accept = passing && sel_valid && bus.out_ready;
    assign eop_accept = pkt_accept && sel_eop;
    assign pass_sop   = passing && sel_sop;

    always_comb begin : ready_fanout
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (state_q == IDLE) begin
                in_ready[i] = 1'b0;
            end else if (active_sel_q == SEL_WIDTH'(i)) begin
                in_ready[i] = sel_ready;
            end else begin
                in_ready[i] = UNSEL_READY;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = passing && sel_valid;
    assign bus.out_sop   = pass_sop;
    assign bus.out_eop   = passing && sel_eop;
    assign bus.out_data  = sel_data;

    vip_switch_plane_counter #(
        .NUMBER_OF_COLOUR_PLANES      (NUMBER_OF_COLOUR_PLANES),
        .LOG2_NUMBER_OF_COLOUR_PLANES (LOG2_NUMBER_OF_COLOUR_PLANES)
    ) u_plane_counter (
        .clk               (clk),
        .rst               (rst),
        .hd_sdn_i          (hd_sdn),
        .accept_i          (pkt_accept),
        .sop_i             (pass_sop),
        .plane_o           (plane),
        .start_of_sample_o (out_start_of_sample)
    );

    assign commit_ok = ctrl_commit && ({1'b0, ctrl_sel} < SEL_LIMIT);
    assign have_pend = pend_q || commit_ok;
    assign err_set   = eop_accept && !hd_sdn && (plane != PLANE_LAST);

    always_comb begin : next_state
        state_d      = state_q;
        active_sel_d = active_sel_q;
        pend_sel_d   = commit_ok ? ctrl_sel : pend_sel_q;
        pend_d       = have_pend;
        done_d       = 1'b0;
        apply        = 1'b0;
        err_d        = err_set ? 1'b1 : (commit_ok ? 1'b0 : err_q);
        unique case (state_q)
            IDLE: begin
                if (have_pend) begin
                    state_d = WAIT_SOP;
                    apply   = 1'b1;
                end
            end
            WAIT_SOP: begin
                if (pkt_accept && !sel_eop) begin
                    state_d = IN_PKT;
                end else if (have_pend && !pkt_accept) begin
                    apply = 1'b1;
                end
            end
            IN_PKT: begin
                if (eop_accept) begin
                    state_d = WAIT_SOP;
                    apply   = have_pend;
                end
            end
            default: state_d = IDLE;
        endcase
        // A commit arriving on the applying cycle itself is honoured (last wins)
        if (apply) begin
            active_sel_d = pend_sel_d;
            pend_d       = 1'b0;
            done_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            active_sel_q <= '0;
            pend_sel_q   <= '0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            pend_sel_q   <= pend_sel_d;
            pend_q       <= pend_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign ctrl_pending       = pend_q;
    assign switch_done        = done_q;
    assign active_sel         = active_sel_q;
    assign err_partial_sample = err_q;

endmodule
